// File: rtl/scramble_sequencer_if.sv
`default_nettype none
// ============================================================================
// scramble_sequencer_if : player-input / grid-cell bus of the scramble sequencer
// Revision : 1.0
// ============================================================================
interface scramble_sequencer_if;
    logic       start;
    logic       user_fire;
    logic       user_nRow;
    logic [3:0] user_row_column;
    logic       user_error;
    logic [3:0] row_out;
    logic [3:0] col_out;
    logic       fire_out;
    logic       busy;
    logic       done;
    logic [7:0] moves_left;

    modport master (
        output start,
        output user_fire,
        output user_nRow,
        output user_row_column,
        output user_error,
        input  row_out,
        input  col_out,
        input  fire_out,
        input  busy,
        input  done,
        input  moves_left
    );

    modport slave (
        input  start,
        input  user_fire,
        input  user_nRow,
        input  user_row_column,
        input  user_error,
        output row_out,
        output col_out,
        output fire_out,
        output busy,
        output done,
        output moves_left
    );
endinterface
`default_nettype wire

// File: rtl/scramble_sequencer.sv
`default_nettype none
// ============================================================================
// scramble_sequencer : player pass-through and paced LFSR-driven grid scrambler
// Revision : 1.0
// ============================================================================
module scramble_sequencer #(
    parameter int unsigned NUM_MOVES   = 16,
    parameter int unsigned PACE_CYCLES = 1024,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    scramble_sequencer_if.slave  bus
);

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] c_lfsr_taps   = 16'hB400;
    localparam logic [15:0] c_seed        = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam int          c_pace_w      = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
    localparam logic [c_pace_w-1:0] c_pace_reload = c_pace_w'(PACE_CYCLES - 1);
    localparam logic [7:0]  c_num_moves   = 8'(NUM_MOVES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PACE   = 2'd1,
        S_PULSE  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t              state_q,       state_d;
    logic [15:0]         lfsr_q,        lfsr_d;
    logic                start_prev_q,  start_prev_d;
    logic                fire_prev_q,   fire_prev_d;
    logic [c_pace_w-1:0] pace_cnt_q,    pace_cnt_d;
    logic [2:0]          prev_move_q,   prev_move_d;
    logic                prev_valid_q,  prev_valid_d;
    logic [3:0]          row_out_q,     row_out_d;
    logic [3:0]          col_out_q,     col_out_d;
    logic                fire_out_q,    fire_out_d;
    logic                busy_q,        busy_d;
    logic                done_q,        done_d;
    logic [7:0]          moves_left_q,  moves_left_d;

    logic [15:0]         w_lfsr_next;
    logic                w_start_rise;
    logic                w_fire_rise;
    logic [2:0]          w_draw_raw;
    logic [2:0]          w_draw_move;
    logic [3:0]          w_draw_onehot;

    always_comb begin
        w_lfsr_next   = lfsr_q[0] ? ((lfsr_q >> 1) ^ c_lfsr_taps) : (lfsr_q >> 1);
        w_start_rise  = bus.start & ~start_prev_q;
        w_fire_rise   = bus.user_fire & ~fire_prev_q;
        // move = {sel_nRow, idx}; bump idx so a move never undoes the previous one
        w_draw_raw    = lfsr_q[2:0];
        w_draw_move   = w_draw_raw;
        if (prev_valid_q && (w_draw_raw == prev_move_q)) begin
            w_draw_move = {w_draw_raw[2], w_draw_raw[1:0] + 2'd1};
        end
        w_draw_onehot = 4'b0001 << w_draw_move[1:0];
    end

    always_comb begin
        state_d      = state_q;
        lfsr_d       = w_lfsr_next;
        start_prev_d = bus.start;
        fire_prev_d  = bus.user_fire;
        pace_cnt_d   = pace_cnt_q;
        prev_move_d  = prev_move_q;
        prev_valid_d = prev_valid_q;
        row_out_d    = row_out_q;
        col_out_d    = col_out_q;
        fire_out_d   = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        moves_left_d = moves_left_q;

        case (state_q)
            S_IDLE: begin
                if (w_start_rise) begin
                    row_out_d = 4'b0000;
                    col_out_d = 4'b0000;
                    if (c_num_moves == 8'd0) begin
                        state_d = S_FINISH;
                    end else begin
                        moves_left_d = c_num_moves;
                        pace_cnt_d   = c_pace_reload;
                        busy_d       = 1'b1;
                        prev_valid_d = 1'b0;
                        state_d      = S_PACE;
                    end
                end else if (bus.user_error) begin
                    row_out_d = 4'b0000;
                    col_out_d = 4'b0000;
                end else begin
                    if (bus.user_nRow) begin
                        row_out_d = 4'b0000;
                        col_out_d = bus.user_row_column;
                    end else begin
                        row_out_d = bus.user_row_column;
                        col_out_d = 4'b0000;
                    end
                    fire_out_d = w_fire_rise;
                end
            end

            S_PACE: begin
                if (pace_cnt_q == '0) begin
                    row_out_d    = w_draw_move[2] ? 4'b0000 : w_draw_onehot;
                    col_out_d    = w_draw_move[2] ? w_draw_onehot : 4'b0000;
                    prev_move_d  = w_draw_move;
                    prev_valid_d = 1'b1;
                    state_d      = S_PULSE;
                end else begin
                    pace_cnt_d = pace_cnt_q - c_pace_w'(1);
                end
            end

            S_PULSE: begin
                // selection registered last cycle stays on the bus while fire rises
                fire_out_d   = 1'b1;
                moves_left_d = moves_left_q - 8'd1;
                if (moves_left_q == 8'd1) begin
                    state_d = S_FINISH;
                end else begin
                    pace_cnt_d = c_pace_reload;
                    state_d    = S_PACE;
                end
            end

            S_FINISH: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                row_out_d = 4'b0000;
                col_out_d = 4'b0000;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lfsr_q       <= c_seed;
            start_prev_q <= 1'b0;
            fire_prev_q  <= 1'b0;
            pace_cnt_q   <= '0;
            prev_move_q  <= 3'b000;
            prev_valid_q <= 1'b0;
            row_out_q    <= 4'b0000;
            col_out_q    <= 4'b0000;
            fire_out_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            moves_left_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            start_prev_q <= start_prev_d;
            fire_prev_q  <= fire_prev_d;
            pace_cnt_q   <= pace_cnt_d;
            prev_move_q  <= prev_move_d;
            prev_valid_q <= prev_valid_d;
            row_out_q    <= row_out_d;
            col_out_q    <= col_out_d;
            fire_out_q   <= fire_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            moves_left_q <= moves_left_d;
        end
    end

    assign bus.row_out    = row_out_q;
    assign bus.col_out    = col_out_q;
    assign bus.fire_out   = fire_out_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.moves_left = moves_left_q;

endmodule
`default_nettype wire

// File: tb/tb_scramble_sequencer.sv
`default_nettype none
// ============================================================================
// tb_scramble_sequencer : directed self-checking bench for scramble_sequencer
// Revision : 1.0
// ============================================================================
module tb_scramble_sequencer;

    localparam int unsigned NUM_MOVES   = 3;
    localparam int unsigned PACE_CYCLES = 4;
    localparam logic [15:0] SEED        = 16'hACE1;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic [15:0] m_lfsr;

    typedef struct {
        logic       nrow;
        logic [3:0] rc;
        logic       err;
        logic       fire;
        logic [3:0] e_row;
        logic [3:0] e_col;
        logic       e_fire;
    } vec_t;

    vec_t vecs [10];

    scramble_sequencer_if bus ();
    scramble_sequencer_if bus0 ();

    scramble_sequencer #(
        .NUM_MOVES   (NUM_MOVES),
        .PACE_CYCLES (PACE_CYCLES),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    scramble_sequencer #(
        .NUM_MOVES   (0),
        .PACE_CYCLES (PACE_CYCLES),
        .LFSR_SEED   (SEED)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    // Reference LFSR: equals the design's LFSR state between clock edges
    always @(posedge clk) m_lfsr <= reset ? SEED : lfsr_step(m_lfsr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic zero_inputs();
        bus.start           = 1'b0;
        bus.user_fire       = 1'b0;
        bus.user_nRow       = 1'b0;
        bus.user_row_column = 4'b0000;
        bus.user_error      = 1'b0;
    endtask

    // Earliest idle wait whose first two raw draws are both (nRow=1, idx=2)
    function automatic int find_collision_wait(input logic [15:0] v0);
        logic [15:0] s;
        logic [15:0] d;
        s = v0;
        for (int w = 0; w < 20000; w++) begin
            d = s;
            for (int i = 0; i < 4; i++) d = lfsr_step(d);
            if (d[2:0] == 3'b110) begin
                for (int i = 0; i < 5; i++) d = lfsr_step(d);
                if (d[2:0] == 3'b110) return w;
            end
            s = lfsr_step(s);
        end
        return -1;
    endfunction

    task automatic run_scramble(input bit want_collision);
        logic [2:0]  mv [NUM_MOVES];
        logic [15:0] v;
        logic [2:0]  raw;
        logic [7:0]  prev_sel;
        logic [7:0]  cur_sel;
        logic [3:0]  e_row;
        logic [3:0]  e_col;
        logic [7:0]  e_ml;
        int          k;
        int          w;
        @(negedge clk);
        zero_inputs();
        @(negedge clk);
        if (want_collision) begin
            w = find_collision_wait(m_lfsr);
            if (w < 0) begin
                checks++;
                failures++;
                $display("FAIL collision_search: no start slot found, required one");
                return;
            end
            repeat (w) @(negedge clk);
        end
        v = m_lfsr;
        for (int i = 0; i < 4; i++) v = lfsr_step(v);
        for (int m = 0; m < NUM_MOVES; m++) begin
            raw = v[2:0];
            if (m > 0) begin
                if (raw == mv[m-1]) raw[1:0] = raw[1:0] + 2'd1;
            end
            mv[m] = raw;
            for (int i = 0; i < 5; i++) v = lfsr_step(v);
        end
        // start and a user fire edge together: start must win
        bus.start     = 1'b1;
        bus.user_fire = 1'b1;
        prev_sel      = 8'h00;
        for (int t = 0; t <= 16; t++) begin
            @(posedge clk);
            #1;
            e_ml = (t < 5) ? 8'd3 : (t < 10) ? 8'd2 : (t < 15) ? 8'd1 : 8'd0;
            e_row = 4'b0000;
            e_col = 4'b0000;
            if (t >= 4 && t <= 15) begin
                k = (t - 4) / 5;
                if (mv[k][2]) e_col = 4'b0001 << mv[k][1:0];
                else          e_row = 4'b0001 << mv[k][1:0];
            end
            check($sformatf("scr t%0d fire", t), 32'(bus.fire_out), 32'((t == 5 || t == 10 || t == 15)));
            check($sformatf("scr t%0d busy", t), 32'(bus.busy), 32'((t <= 15)));
            check($sformatf("scr t%0d done", t), 32'(bus.done), 32'((t == 16)));
            check($sformatf("scr t%0d moves_left", t), 32'(bus.moves_left), 32'(e_ml));
            check($sformatf("scr t%0d row", t), 32'(bus.row_out), 32'(e_row));
            check($sformatf("scr t%0d col", t), 32'(bus.col_out), 32'(e_col));
            if (bus.fire_out) begin
                cur_sel = {bus.row_out, bus.col_out};
                check($sformatf("scr t%0d onehot", t), 32'($countones(cur_sel)), 32'd1);
                if (t > 5) check($sformatf("scr t%0d repeat", t), 32'((cur_sel != prev_sel)), 32'd1);
                prev_sel = cur_sel;
            end
            if (want_collision && t == 9) begin
                check("collision col", 32'(bus.col_out), 32'(4'b1000));
                check("collision row", 32'(bus.row_out), 32'(4'b0000));
            end
            if (t < 16) begin
                @(negedge clk);
                bus.start           = 1'($urandom_range(0, 1));
                bus.user_fire       = 1'($urandom_range(0, 1));
                bus.user_nRow       = 1'($urandom_range(0, 1));
                bus.user_row_column = 4'($urandom_range(0, 15));
            end
        end
        @(negedge clk);
        zero_inputs();
    endtask

    initial begin
        int fires;
        int dones;

        vecs[0] = '{1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0};
        vecs[1] = '{1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b1};
        vecs[2] = '{1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0};
        vecs[3] = '{1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0};
        vecs[4] = '{1'b1, 4'b0010, 1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0};
        vecs[5] = '{1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0};
        vecs[6] = '{1'b1, 4'b1000, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0};
        vecs[7] = '{1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0};
        vecs[8] = '{1'b0, 4'b0001, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b1};
        vecs[9] = '{1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0};

        zero_inputs();
        bus0.start           = 1'b0;
        bus0.user_fire       = 1'b0;
        bus0.user_nRow       = 1'b0;
        bus0.user_row_column = 4'b0000;
        bus0.user_error      = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset row", 32'(bus.row_out), 32'd0);
        check("reset col", 32'(bus.col_out), 32'd0);
        check("reset fire", 32'(bus.fire_out), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset moves_left", 32'(bus.moves_left), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // IDLE pass-through vectors
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.user_nRow       = vecs[i].nrow;
            bus.user_row_column = vecs[i].rc;
            bus.user_error      = vecs[i].err;
            bus.user_fire       = vecs[i].fire;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d row", i), 32'(bus.row_out), 32'(vecs[i].e_row));
            check($sformatf("vec%0d col", i), 32'(bus.col_out), 32'(vecs[i].e_col));
            check($sformatf("vec%0d fire", i), 32'(bus.fire_out), 32'(vecs[i].e_fire));
        end

        // fire held high for 10 cycles yields a single pulse
        @(negedge clk);
        zero_inputs();
        bus.user_row_column = 4'b0100;
        @(negedge clk);
        bus.user_fire = 1'b1;
        fires = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                check("held first fire", 32'(bus.fire_out), 32'd1);
                check("held row", 32'(bus.row_out), 32'(4'b0100));
                check("held col", 32'(bus.col_out), 32'd0);
            end
            if (bus.fire_out) fires++;
        end
        check("held fire count", 32'(fires), 32'd1);

        // full scramble, then one with a forced immediate-undo collision
        run_scramble(1'b0);
        run_scramble(1'b1);

        // reset mid-scramble aborts without a done pulse
        @(negedge clk);
        zero_inputs();
        @(negedge clk);
        bus.start = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort moves_left before reset", 32'(bus.moves_left), 32'd2);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort row", 32'(bus.row_out), 32'd0);
        check("abort col", 32'(bus.col_out), 32'd0);
        check("abort fire", 32'(bus.fire_out), 32'd0);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort moves_left", 32'(bus.moves_left), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("abort no done", 32'(dones), 32'd0);
        run_scramble(1'b0);

        // NUM_MOVES = 0: prompt done, no fire, no retrigger on held start
        @(negedge clk);
        bus0.start = 1'b1;
        dones = 0;
        fires = 0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            if (bus0.done) dones++;
            if (bus0.fire_out) fires++;
        end
        check("zero-move done count", 32'(dones), 32'd1);
        check("zero-move fire count", 32'(fires), 32'd0);
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus0.done) dones++;
            if (bus0.fire_out) fires++;
        end
        check("zero-move held start done", 32'(dones), 32'd0);
        check("zero-move held start fire", 32'(fires), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scramble_sequencer.md
Name: scramble_sequencer

Overview:
Sits directly upstream of the 16 grid cells and replaces the hardwired scramble mux in the top level. In IDLE it passes the player's validated row/column selection and fire edge through to the cells. On a scramble request it takes over the grid bus and issues NUM_MOVES paced, pseudo-random single-line toggles. It then signals completion and returns control to the player.

Parameters:
NUM_MOVES, 16, number of random moves per scramble (0..255)
PACE_CYCLES, 1024, clk cycles between scramble moves (>=1)
LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  debounced scramble request level; rising edge detected internally
user_fire  input  1  debounced fire level from player
user_nRow  input  1  0 = row select, 1 = column select
user_row_column  input  4  one-hot line select from player
user_error  input  1  high when player switch pattern is invalid
row_out  output  4  one-hot row enable to cells
col_out  output  4  one-hot column enable to cells
fire_out  output  1  single-cycle fire pulse to cells
busy  output  1  high while scramble is in progress
done  output  1  single-cycle pulse when scramble completes
moves_left  output  8  remaining scramble moves

Behaviour:
- All outputs are registered. On reset: row_out=0, col_out=0, fire_out=0, busy=0, done=0, moves_left=0, state=IDLE, LFSR=seed, edge registers=0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every cycle, including in IDLE, so the scramble depends on when start is pressed. Never reaches 0.
- States: IDLE, PACE, PULSE, FINISH.
- IDLE, pass-through with 1-cycle latency:
  - If user_error=1: row_out=col_out=0 and fire_out=0.
  - Otherwise: user_nRow=0 drives row_out=user_row_column and col_out=0; user_nRow=1 drives col_out=user_row_column and row_out=0.
  - fire_out=1 for exactly one cycle on a user_fire 0->1 edge. A held level produces no repeats.
- IDLE, start rising edge:
  - If NUM_MOVES=0: go to FINISH.
  - Otherwise: moves_left=NUM_MOVES, pace counter=PACE_CYCLES-1, busy=1, row_out=col_out=0, then go to PACE.
  - If the start edge and the user_fire edge arrive in the same cycle, start wins and no user fire is emitted.
- PACE: the pace counter decrements each cycle. At count 0, draw a move:
  - sel_nRow = LFSR[2]; idx = LFSR[1:0].
  - If (sel_nRow, idx) equals the previous scramble move, idx = idx+1 mod 4. This prevents an immediate undo. The previous-move register is cleared at scramble start.
  - Load row_out/col_out one-hot from the drawn move and go to PULSE.
- PULSE (1 cycle):
  - fire_out=1, with row_out/col_out held stable. This is the same selection that was visible in the preceding cycle.
  - moves_left decrements.
  - If the new value is 0, go to FINISH. Otherwise reload the pace counter and go to PACE.
  - row_out/col_out stay asserted until the next draw.
- FINISH (1 cycle): done=1, busy=0, row_out=col_out=0, fire_out=0, then go to IDLE.
- While busy: all user inputs and further start edges are ignored. A start level held through FINISH does not retrigger, because a new rising edge is required.
- A reset asserted mid-scramble aborts immediately to reset values. No done pulse is produced.
- Exactly one of row_out/col_out is non-zero during PULSE, and it has exactly one bit set.
- fire_out is never high on two consecutive cycles.

Test Plan:
- Reset, IDLE, user_nRow=0, user_row_column=4'b0100, user_fire 0->1 held 10 cycles -> row_out=4'b0100 and col_out=0 one cycle after the input; fire_out high for exactly 1 cycle.
- IDLE, user_error=1, user_fire edge -> row_out=col_out=0 and no fire_out pulse.
- NUM_MOVES=3, PACE_CYCLES=4, start pulse -> busy rises next cycle. Exactly 3 fire_out pulses, spaced 5 cycles apart. moves_left steps 3->2->1->0. The selection is one-hot on every pulse, and no two consecutive moves are identical. done is high for 1 cycle after the third pulse, then busy=0.
- Force LFSR so that two consecutive draws give (nRow=1, idx=2) -> the second move is emitted as col_out=4'b1000.
- Mid-scramble (moves_left=2), assert reset for 1 cycle -> all outputs 0 next cycle, no done pulse. A subsequent start edge runs a full NUM_MOVES scramble.
- NUM_MOVES=0, start edge -> done pulse within 2 cycles and no fire_out. Holding start high afterwards produces no second done pulse.
